// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write bank and its read mux.
package regfile_pkg;

    localparam int unsigned NREG          = 8;
    localparam int unsigned ADDR_W        = 3;
    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } bank_state_t;

endpackage

// File: rtl/regfile_wr_decode.sv
// 3-to-8 one-hot decoder with enable; all-zero output when disabled.
module regfile_wr_decode
    import regfile_pkg::*;
(
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [NREG-1:0]   onehot_c
);

    always_comb begin
        onehot_c = '0;
        if (en_i) begin
            onehot_c[addr_i] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_bank.sv
// 8-entry register bank: valid/ready write port, 8-cycle clear sweep, per-entry
// written-since-clear flags, all entries driven in parallel to the read mux.
module regfile_write_bank
    import regfile_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [2:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clr_req,
    output logic             busy,
    output logic             clr_done,
    output logic [7:0]       reg_valid,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic [WIDTH-1:0] q4,
    output logic [WIDTH-1:0] q5,
    output logic [WIDTH-1:0] q6,
    output logic [WIDTH-1:0] q7
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NREG - 1);

    bank_state_t       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              clr_done_q, clr_done_d;
    logic [WIDTH-1:0]  mem_q [NREG];
    logic [WIDTH-1:0]  mem_d [NREG];
    logic [NREG-1:0]   valid_q, valid_d;
    logic [NREG-1:0]   wr_hot, clr_hot;
    logic              wr_fire;
    logic              sweeping;

    assign sweeping = (state_q == CLEAR);
    assign wr_ready = (state_q == IDLE);
    assign wr_fire  = wr_valid & wr_ready;

    regfile_wr_decode u_wr_dec (
        .en_i     (wr_fire),
        .addr_i   (wr_addr),
        .onehot_c (wr_hot)
    );

    regfile_wr_decode u_clr_dec (
        .en_i     (sweeping),
        .addr_i   (ptr_q),
        .onehot_c (clr_hot)
    );

    // Sweep controller
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        clr_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                if (ptr_q == LAST_PTR) begin
                    state_d    = IDLE;
                    ptr_d      = '0;
                    clr_done_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // Per-entry update; the sweep wins over a write to the same entry
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < NREG; i++) begin
            mem_d[i] = mem_q[i];
            if (clr_hot[i]) begin
                mem_d[i]   = CLR_VALUE;
                valid_d[i] = 1'b0;
            end else if (wr_hot[i]) begin
                mem_d[i]   = wr_data;
                valid_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            clr_done_q <= 1'b0;
            valid_q    <= '0;
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            clr_done_q <= clr_done_d;
            valid_q    <= valid_d;
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign busy      = sweeping;
    assign clr_done  = clr_done_q;
    assign reg_valid = valid_q;
    assign q0        = mem_q[0];
    assign q1        = mem_q[1];
    assign q2        = mem_q[2];
    assign q3        = mem_q[3];
    assign q4        = mem_q[4];
    assign q5        = mem_q[5];
    assign q6        = mem_q[6];
    assign q7        = mem_q[7];

endmodule
